rv32_mul_seq: RTL and testbench

RV32_MUL_SEQ -- requirements
Module: rv32_mul_seq

---
 rtl/rv32_mul_seq.sv | 166 ++++++++++++++++
 tb/tb_rv32_mul_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mul_seq.sv
// rv32_mul_seq: sequential radix-2 shift-add multiplier for the RV32 M-extension
// multiply group (MUL/MULH/MULHSU/MULHU). Operands are converted to magnitudes
// on acceptance, multiplied unsigned over 32 CALC cycles, then the sign is
// re-applied in a single SIGN cycle before the result word is published in DONE.
module rv32_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        MUL_OP    = 2'b00,
        MULH_OP   = 2'b01,
        MULHSU_OP = 2'b10,
        MULHU_OP  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    // Magnitude of a possibly signed operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] f_abs(input logic [31:0] x, input logic is_signed);
        logic [31:0] mag;
        if (is_signed && x[31]) begin
            mag = (~x) + 32'd1;
        end else begin
            mag = x;
        end
        return mag;
    endfunction

    state_t      r_state;
    state_t      w_state_fsm;
    state_t      w_state_nxt;
    mul_op_t     r_op;
    mul_op_t     w_op_in;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_a_signed;
    logic        w_b_signed;
    logic [32:0] w_sum;
    logic [63:0] w_acc_step;
    logic [63:0] w_acc_sign;

    assign w_op_in    = mul_op_t'(op);
    assign w_a_signed = (w_op_in == MULH_OP) || (w_op_in == MULHSU_OP);
    assign w_b_signed = (w_op_in == MULH_OP);

    // One shift-add step: add multiplicand into the upper 33 bits when the multiplier LSB is set, then shift right.
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + {1'b0, (r_mplier[0] ? r_mcand : 32'd0)};
        w_acc_step = {w_sum, r_acc[31:1]};
        w_acc_sign = r_neg ? ((~r_acc) + 64'd1) : r_acc;
    end

    // Sequencing of the multiply without regard to flush.
    always_comb begin
        w_state_fsm = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_fsm = CALC;
                end else begin
                    w_state_fsm = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == 5'd31) begin
                    w_state_fsm = SIGN;
                end else begin
                    w_state_fsm = CALC;
                end
            end
            SIGN:    w_state_fsm = DONE;
            DONE:    w_state_fsm = IDLE;
            default: w_state_fsm = IDLE;
        endcase
    end

    // Flush overrides every transition and returns the unit to IDLE.
    always_comb begin
        w_state_nxt = IDLE;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            w_state_nxt = w_state_fsm;
        end
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Operand capture, shift-add datapath, sign fix-up and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MUL_OP;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        r_op     <= w_op_in;
                        r_mcand  <= f_abs(rs1_data, w_a_signed);
                        r_mplier <= f_abs(rs2_data, w_b_signed);
                        r_neg    <= (w_a_signed & rs1_data[31]) ^ (w_b_signed & rs2_data[31]);
                        r_acc    <= 64'd0;
                        r_cnt    <= 5'd0;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_step;
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                end
                SIGN: begin
                    r_acc <= w_acc_sign;
                    // An aborted op must leave the previous result visible.
                    if (!flush) begin
                        r_result <= (r_op == MUL_OP) ? w_acc_sign[31:0] : w_acc_sign[63:32];
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_rv32_mul_seq.sv
// Self-checking bench for rv32_mul_seq: directed corner products, randomized
// products against a wide-arithmetic reference, back-to-back starts, flush and
// mid-operation reset behaviour.
module tb_rv32_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    rv32_mul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 66 bits, multiply exactly, pick the word.
    function automatic logic [31:0] ref_mul(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = (f_op == 2'b01 || f_op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
        eb = (f_op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (f_op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, scramble inputs after acceptance, report result/latency/busy count.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b;
        lat = 0; bcnt = 0; res = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            end
            if (busy) bcnt++;
            if (done && lat == 0) begin
                lat = k; res = result;
            end
            if (lat != 0 && k > lat) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1_data = 32'd0; rs2_data = 32'd0;
        @(negedge clk); @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected 00000000", result); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [6] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] t_a   [6] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] t_b   [6] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] t_exp [6] = '{32'h0000002A, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'h80000000, 32'h40000000};
        logic [31:0] res;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat, bcnt);
            vectors++; if (res !== t_exp[i]) begin miscompares++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
            vectors++; if (lat != 34) begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d expected 34", i, lat); end
            vectors++; if (bcnt != 34) begin miscompares++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 34", i, bcnt); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_v;
        logic [1:0]  o;
        int lat, bcnt;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom); a = pick_operand(); b = pick_operand();
            exp_v = ref_mul(o, a, b);
            run_op(o, a, b, res, lat, bcnt);
            vectors++; if (res !== exp_v) begin miscompares++; $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, res, exp_v); end
            vectors++; if (lat != 34) begin miscompares++; $display("FAIL random_latency: got %0d expected 34", lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2, b2, exp2, r1, r2;
        int dcnt, d1lat, d2lat;
        a2 = $urandom; b2 = $urandom; exp2 = ref_mul(2'b11, a2, b2);
        dcnt = 0; d1lat = 0; d2lat = 0; r1 = 32'd0; r2 = 32'd0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd7; rs2_data = 32'd6;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin op = 2'b11; rs1_data = a2; rs2_data = b2; end
            if (k == 36) start = 1'b0;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin d1lat = k; r1 = result; end
                else if (dcnt == 2) begin d2lat = k; r2 = result; end
            end
        end
        vectors++; if (dcnt != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", dcnt); end
        vectors++; if (d1lat != 34) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 34", d1lat); end
        vectors++; if (r1 !== 32'h0000002A) begin miscompares++; $display("FAIL b2b_first_result: got %h expected 0000002a", r1); end
        vectors++; if (d2lat != 69) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 69", d2lat); end
        vectors++; if (r2 !== exp2) begin miscompares++; $display("FAIL b2b_second_result: got %h expected %h", r2, exp2); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, bcnt, dcnt;
        run_op(2'b00, 32'd7, 32'd6, res, lat, bcnt);
        vectors++; if (res !== 32'h0000002A) begin miscompares++; $display("FAIL flush_setup_result: got %h expected 0000002a", res); end
        // Flush in CALC cycle 10.
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs1_data = $urandom; rs2_data = $urandom;
        dcnt = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dcnt++;
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
            end
        end
        vectors++; if (dcnt != 0) begin miscompares++; $display("FAIL flush_calc_done_count: got %0d expected 0", dcnt); end
        vectors++; if (result !== 32'h0000002A) begin miscompares++; $display("FAIL flush_calc_result: got %h expected 0000002a", result); end
        // Flush in SIGN: no done, result untouched.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd9; rs2_data = 32'd9;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 33) flush = 1'b1;
            if (k == 34) begin
                flush = 1'b0;
                vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL flush_sign_done: got %b expected 0", done); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_sign_busy: got %b expected 0", busy); end
                vectors++; if (result !== 32'h0000002A) begin miscompares++; $display("FAIL flush_sign_result: got %h expected 0000002a", result); end
            end
        end
        // Flush and start together in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; rs1_data = 32'd2; rs2_data = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_start_idle_busy: got %b expected 0", busy); end
        // Flush in DONE: the committed op still pulses and publishes.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd3; rs2_data = 32'd5;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 34) begin
                vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL flush_done_pulse: got %b expected 1", done); end
                flush = 1'b1;
            end
            if (k == 35) begin
                flush = 1'b0;
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_done_busy: got %b expected 0", busy); end
                vectors++; if (result !== 32'h0000000F) begin miscompares++; $display("FAIL flush_done_result: got %h expected 0000000f", result); end
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res;
        int lat, bcnt, dcnt;
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = $urandom; rs2_data = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL rst_mid_result: got %h expected 00000000", result); end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        vectors++; if (dcnt != 0) begin miscompares++; $display("FAIL rst_mid_stray_done: got %0d expected 0", dcnt); end
        run_op(2'b00, 32'd3, 32'd5, res, lat, bcnt);
        vectors++; if (res !== 32'h0000000F) begin miscompares++; $display("FAIL rst_mid_next_result: got %h expected 0000000f", res); end
        vectors++; if (lat != 34) begin miscompares++; $display("FAIL rst_mid_next_latency: got %0d expected 34", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
